// File: rtl/aemb2_xwb_slave_if.sv
// XWB accelerator bus bundle between the core (master) and the slave
// terminating it. Address is a word address covering [AEMB_XWB+1:2].
interface aemb2_xwb_slave_if #(
    parameter int AEMB_XWB = 3
);
    logic [AEMB_XWB+1:2] xwb_adr_i;
    logic [31:0]         xwb_dat_i;
    logic [3:0]          xwb_sel_i;
    logic                xwb_stb_i;
    logic                xwb_cyc_i;
    logic                xwb_wre_i;
    logic                xwb_tag_i;
    logic [31:0]         xwb_dat_o;
    logic                xwb_ack_o;

    modport master (
        output xwb_adr_i, xwb_dat_i, xwb_sel_i, xwb_stb_i, xwb_cyc_i,
               xwb_wre_i, xwb_tag_i,
        input  xwb_dat_o, xwb_ack_o
    );

    modport slave (
        input  xwb_adr_i, xwb_dat_i, xwb_sel_i, xwb_stb_i, xwb_cyc_i,
               xwb_wre_i, xwb_tag_i,
        output xwb_dat_o, xwb_ack_o
    );
endinterface

// File: rtl/aemb2_xwb_slave.sv
// XWB accelerator slave: bus puts feed a TX FIFO drained by the accelerator,
// bus gets pop an RX FIFO filled by the accelerator. tag=0 stalls on
// full/empty, tag=1 never stalls (drops put / returns zero).
// Optional macro AEMB2_XWB_STATUS_EN: all-ones address becomes a read-only
// status register {8'h0, tx_count[11:0], rx_count[11:0]}.
module aemb2_xwb_slave #(
    parameter int AEMB_XWB = 3,
    parameter int AEMB_FDW = 4
) (
    input  logic                sys_clk_i,
    input  logic                sys_rst_i,
    aemb2_xwb_slave_if.slave    xwb,
    output logic [31:0]         tx_dat_o,
    output logic                tx_vld_o,
    input  logic                tx_rdy_i,
    input  logic [31:0]         rx_dat_i,
    input  logic                rx_vld_i,
    output logic                rx_rdy_o
);
    localparam int DEPTH = 1 << AEMB_FDW;

    typedef logic [AEMB_FDW:0]   cnt_t;
    typedef logic [AEMB_FDW-1:0] ptr_t;

    logic [31:0] tx_mem [DEPTH];
    logic [31:0] rx_mem [DEPTH];
    ptr_t        tx_wr, tx_rd, rx_wr, rx_rd;
    cnt_t        tx_count, rx_count;
    logic        ack_q;
    logic [31:0] dat_q;

    logic        req, status_hit, tx_full, rx_empty;
    logic        accept, tx_push, tx_pop, rx_push, rx_pop;
    logic [31:0] status_word, rd_word;

    // Byte selects carry no meaning here (full-word transfers only).
    logic unused_sel;
    assign unused_sel = ^xwb.xwb_sel_i;

    assign req      = xwb.xwb_cyc_i & xwb.xwb_stb_i & ~ack_q;
    // Count MSB set means exactly DEPTH words stored.
    assign tx_full  = tx_count[AEMB_FDW];
    assign rx_empty = (rx_count == '0);

    assign tx_vld_o = (tx_count != '0);
    assign tx_dat_o = tx_mem[tx_rd];
    assign rx_rdy_o = ~rx_count[AEMB_FDW];
    assign tx_pop   = tx_vld_o & tx_rdy_i;
    assign rx_push  = rx_vld_i & rx_rdy_o;

    assign xwb.xwb_ack_o = ack_q;
    assign xwb.xwb_dat_o = dat_q;

`ifdef AEMB2_XWB_STATUS_EN
    assign status_hit = (xwb.xwb_adr_i == {AEMB_XWB{1'b1}});
`else
    logic unused_adr;
    assign unused_adr = ^xwb.xwb_adr_i;
    assign status_hit = 1'b0;
`endif

    assign status_word = {8'h0, {(11 - AEMB_FDW){1'b0}}, tx_count,
                                {(11 - AEMB_FDW){1'b0}}, rx_count};

    // Acceptance decision and bus-side FIFO strobes from registered counts.
    always_comb begin
        accept  = 1'b0;
        tx_push = 1'b0;
        rx_pop  = 1'b0;
        rd_word = 32'h0;
        if (req) begin
            if (status_hit) begin
                accept  = 1'b1;
                rd_word = status_word;
            end else if (xwb.xwb_wre_i) begin
                accept  = xwb.xwb_tag_i | ~tx_full;
                tx_push = ~tx_full;
            end else begin
                accept  = xwb.xwb_tag_i | ~rx_empty;
                rx_pop  = ~rx_empty;
                rd_word = rx_empty ? 32'h0 : rx_mem[rx_rd];
            end
        end
    end

    // Ack, read data, pointers and counts.
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_i) begin
            ack_q    <= 1'b0;
            dat_q    <= 32'h0;
            tx_wr    <= '0;
            tx_rd    <= '0;
            rx_wr    <= '0;
            rx_rd    <= '0;
            tx_count <= '0;
            rx_count <= '0;
        end else begin
            ack_q <= accept;
            if (accept)
                dat_q <= xwb.xwb_wre_i ? 32'h0 : rd_word;
            if (tx_push) tx_wr <= tx_wr + 1'b1;
            if (tx_pop)  tx_rd <= tx_rd + 1'b1;
            if (rx_push) rx_wr <= rx_wr + 1'b1;
            if (rx_pop)  rx_rd <= rx_rd + 1'b1;
            tx_count <= tx_count + cnt_t'(tx_push) - cnt_t'(tx_pop);
            rx_count <= rx_count + cnt_t'(rx_push) - cnt_t'(rx_pop);
        end
    end

    // FIFO storage; contents need no reset since pointers define validity.
    always_ff @(posedge sys_clk_i) begin
        if (tx_push) tx_mem[tx_wr] <= xwb.xwb_dat_i;
        if (rx_push) rx_mem[rx_wr] <= rx_dat_i;
    end
endmodule

// File: tb/tb_aemb2_xwb_slave.sv
// Directed bench for aemb2_xwb_slave (AEMB_XWB=3, AEMB_FDW=4).
module tb_aemb2_xwb_slave;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] tx_dat;
    logic        tx_vld;
    logic        tx_rdy = 1'b0;
    logic [31:0] rx_dat = 32'h0;
    logic        rx_vld = 1'b0;
    logic        rx_rdy;
    int          n_cmp = 0;
    int          n_err = 0;

    aemb2_xwb_slave_if #(.AEMB_XWB(3)) bus ();

    aemb2_xwb_slave #(.AEMB_XWB(3), .AEMB_FDW(4)) dut (
        .sys_clk_i (clk),
        .sys_rst_i (rst),
        .xwb       (bus),
        .tx_dat_o  (tx_dat),
        .tx_vld_o  (tx_vld),
        .tx_rdy_i  (tx_rdy),
        .rx_dat_i  (rx_dat),
        .rx_vld_i  (rx_vld),
        .rx_rdy_o  (rx_rdy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.xwb_cyc_i = 1'b0;
        bus.xwb_stb_i = 1'b0;
        bus.xwb_wre_i = 1'b0;
        bus.xwb_tag_i = 1'b0;
        bus.xwb_adr_i = 3'd0;
        bus.xwb_dat_i = 32'h0;
        bus.xwb_sel_i = 4'hF;
    endtask

    task automatic bus_start(input logic wre, input logic tag,
                             input logic [2:0] adr, input logic [31:0] wd);
        bus.xwb_adr_i = adr;
        bus.xwb_dat_i = wd;
        bus.xwb_wre_i = wre;
        bus.xwb_tag_i = tag;
        bus.xwb_sel_i = 4'hF;
        bus.xwb_cyc_i = 1'b1;
        bus.xwb_stb_i = 1'b1;
    endtask

    // One bus transfer; returns cycles from strobe to ack (bounded to 8),
    // then lets the ack cycle finish so the next call starts clean.
    task automatic bus_req(input logic wre, input logic tag,
                           input logic [2:0] adr, input logic [31:0] wd,
                           output logic got, output int waited,
                           output logic [31:0] rd);
        got = 1'b0;
        waited = 0;
        rd = 32'h0;
        bus_start(wre, tag, adr, wd);
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            waited++;
            if (bus.xwb_ack_o === 1'b1) begin
                got = 1'b1;
                rd = bus.xwb_dat_o;
            end
        end
        bus_idle();
        tick();
    endtask

    task automatic do_reset();
        bus_idle();
        tx_rdy = 1'b0;
        rx_vld = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (bus.xwb_ack_o !== 1'b0 || bus.xwb_dat_o !== 32'h0 ||
            tx_vld !== 1'b0 || rx_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state: ack=%b dat=%h tx_vld=%b rx_rdy=%b, required 0 00000000 0 1",
                     bus.xwb_ack_o, bus.xwb_dat_o, tx_vld, rx_rdy);
        end
    endtask

    task automatic test_single_put();
        logic got; int w; logic [31:0] rd;
        bus_req(1'b1, 1'b0, 3'd0, 32'hDEADBEEF, got, w, rd);
        n_cmp++;
        if (!got || w !== 1) begin
            n_err++;
            $display("FAIL single_put_ack: got=%b latency=%0d, required 1 1", got, w);
        end
        n_cmp++;
        if (tx_vld !== 1'b1 || tx_dat !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL single_put_head: vld=%b dat=%h, required 1 deadbeef", tx_vld, tx_dat);
        end
        tx_rdy = 1'b1;
        tick();
        tx_rdy = 1'b0;
        n_cmp++;
        if (tx_vld !== 1'b0) begin
            n_err++;
            $display("FAIL single_put_drain: tx_vld=%b, required 0", tx_vld);
        end
    endtask

    task automatic test_tx_full();
        logic got; int w; logic [31:0] rd; int bad;
        bad = 0;
        for (int v = 0; v < 16; v++) begin
            bus_req(1'b1, 1'b0, 3'd0, 32'(v), got, w, rd);
            if (!got || w !== 1) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL fill_puts_acked: %0d of 16 not acked in 1 cycle, required 0", bad);
        end
        // 17th blocking put must stall while full
        bus_start(1'b1, 1'b0, 3'd0, 32'd16);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.xwb_ack_o !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL full_put_stall: ack seen %0d of 5 cycles, required 0", bad);
        end
        n_cmp++;
        if (tx_dat !== 32'd0) begin
            n_err++;
            $display("FAIL full_head: tx_dat=%h, required 00000000", tx_dat);
        end
        tx_rdy = 1'b1;
        tick();
        tx_rdy = 1'b0;
        n_cmp++;
        if (bus.xwb_ack_o !== 1'b0) begin
            n_err++;
            $display("FAIL no_bypass_tx: ack=%b on pop cycle, required 0", bus.xwb_ack_o);
        end
        tick();
        n_cmp++;
        if (bus.xwb_ack_o !== 1'b1) begin
            n_err++;
            $display("FAIL stalled_put_ack: ack=%b two cycles after pop, required 1", bus.xwb_ack_o);
        end
        bus_idle();
        tick();
        // non-blocking put to full TX: acked, discarded
        bus_req(1'b1, 1'b1, 3'd0, 32'h00000BAD, got, w, rd);
        n_cmp++;
        if (!got || w !== 1) begin
            n_err++;
            $display("FAIL nb_put_full_ack: got=%b latency=%0d, required 1 1", got, w);
        end
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (tx_vld !== 1'b1 || tx_dat !== 32'(i + 1)) bad++;
            tx_rdy = 1'b1;
            tick();
        end
        tx_rdy = 1'b0;
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL tx_drain_order: %0d of 16 words wrong, required 0", bad);
        end
        n_cmp++;
        if (tx_vld !== 1'b0) begin
            n_err++;
            $display("FAIL tx_drain_empty: tx_vld=%b, required 0", tx_vld);
        end
    endtask

    task automatic test_rx_get();
        logic got; int w; logic [31:0] rd; int bad;
        bus_start(1'b0, 1'b0, 3'd0, 32'h0);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.xwb_ack_o !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL empty_get_stall: ack seen %0d of 3 cycles, required 0", bad);
        end
        rx_vld = 1'b1;
        rx_dat = 32'h12345678;
        tick();
        rx_vld = 1'b0;
        n_cmp++;
        if (bus.xwb_ack_o !== 1'b0) begin
            n_err++;
            $display("FAIL no_bypass_rx: ack=%b on push cycle, required 0", bus.xwb_ack_o);
        end
        tick();
        n_cmp++;
        if (bus.xwb_ack_o !== 1'b1 || bus.xwb_dat_o !== 32'h12345678) begin
            n_err++;
            $display("FAIL stalled_get: ack=%b dat=%h, required 1 12345678",
                     bus.xwb_ack_o, bus.xwb_dat_o);
        end
        bus_idle();
        tick();
        bus_req(1'b0, 1'b1, 3'd0, 32'h0, got, w, rd);
        n_cmp++;
        if (!got || w !== 1 || rd !== 32'h0) begin
            n_err++;
            $display("FAIL nb_get_empty: got=%b latency=%0d dat=%h, required 1 1 00000000",
                     got, w, rd);
        end
    endtask

    task automatic test_simul_tx();
        logic got; int w; logic [31:0] rd; int bad;
        for (int i = 0; i < 3; i++)
            bus_req(1'b1, 1'b0, 3'd0, 32'hA0 + 32'(i), got, w, rd);
        bus_start(1'b1, 1'b0, 3'd0, 32'hA3);
        tx_rdy = 1'b1;
        tick();
        tx_rdy = 1'b0;
        n_cmp++;
        if (bus.xwb_ack_o !== 1'b1) begin
            n_err++;
            $display("FAIL simul_push_ack: ack=%b, required 1", bus.xwb_ack_o);
        end
        bus_idle();
        tick();
        bad = 0;
        for (int i = 1; i < 4; i++) begin
            if (tx_vld !== 1'b1 || tx_dat !== 32'hA0 + 32'(i)) bad++;
            tx_rdy = 1'b1;
            tick();
        end
        tx_rdy = 1'b0;
        n_cmp++;
        if (bad !== 0 || tx_vld !== 1'b0) begin
            n_err++;
            $display("FAIL simul_count3: bad=%0d tx_vld=%b after 3 pops, required 0 0", bad, tx_vld);
        end
    endtask

    task automatic test_rx_full_wrap();
        logic got; int w; logic [31:0] rd; int bad;
        rx_vld = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rx_dat = 32'd100 + 32'(i);
            tick();
        end
        rx_vld = 1'b0;
        n_cmp++;
        if (rx_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL rx_full: rx_rdy=%b, required 0", rx_rdy);
        end
        bus_req(1'b0, 1'b0, 3'd0, 32'h0, got, w, rd);
        n_cmp++;
        if (!got || rd !== 32'd100 || rx_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL rx_full_get: got=%b dat=%h rx_rdy=%b, required 1 00000064 1",
                     got, rd, rx_rdy);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            rx_vld = 1'b1;
            rx_dat = 32'd200 + 32'(i);
            tick();
            rx_vld = 1'b0;
            bus_req(1'b0, 1'b0, 3'd0, 32'h0, got, w, rd);
            if (!got || rd !== ((i < 15) ? 32'd101 + 32'(i) : 32'd200 + 32'(i - 15))) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL rx_wrap_order: %0d of 20 gets wrong, required 0", bad);
        end
    endtask

    task automatic test_addr_decode();
        logic got; int w; logic [31:0] rd;
        do_reset();
`ifdef AEMB2_XWB_STATUS_EN
        for (int i = 0; i < 3; i++)
            bus_req(1'b1, 1'b0, 3'd0, 32'hC0 + 32'(i), got, w, rd);
        rx_vld = 1'b1;
        rx_dat = 32'h55;
        tick();
        tick();
        rx_vld = 1'b0;
        bus_req(1'b0, 1'b0, 3'b111, 32'h0, got, w, rd);
        n_cmp++;
        if (!got || w !== 1 || rd !== 32'h0000_3002) begin
            n_err++;
            $display("FAIL status_get: got=%b latency=%0d dat=%h, required 1 1 00003002", got, w, rd);
        end
        bus_req(1'b1, 1'b0, 3'b111, 32'hFFFF, got, w, rd);
        bus_req(1'b0, 1'b1, 3'b111, 32'h0, got, w, rd);
        n_cmp++;
        if (!got || rd !== 32'h0000_3002) begin
            n_err++;
            $display("FAIL status_put_discard: got=%b dat=%h, required 1 00003002", got, rd);
        end
`else
        bus_req(1'b1, 1'b0, 3'b111, 32'h0000_7777, got, w, rd);
        n_cmp++;
        if (!got || tx_vld !== 1'b1 || tx_dat !== 32'h0000_7777) begin
            n_err++;
            $display("FAIL adr7_put_data: got=%b vld=%b dat=%h, required 1 1 00007777",
                     got, tx_vld, tx_dat);
        end
        rx_vld = 1'b1;
        rx_dat = 32'h55;
        tick();
        rx_vld = 1'b0;
        bus_req(1'b0, 1'b0, 3'b111, 32'h0, got, w, rd);
        n_cmp++;
        if (!got || rd !== 32'h55) begin
            n_err++;
            $display("FAIL adr7_get_data: got=%b dat=%h, required 1 00000055", got, rd);
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic got; int w; logic [31:0] rd; int bad;
        do_reset();
        bus_req(1'b1, 1'b0, 3'd0, 32'hCAFE, got, w, rd);
        rx_vld = 1'b1;
        rx_dat = 32'h77;
        tick();
        rx_vld = 1'b0;
        bus_req(1'b0, 1'b0, 3'd0, 32'h0, got, w, rd);
        bus_start(1'b0, 1'b0, 3'd0, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (bus.xwb_ack_o !== 1'b0 || bus.xwb_dat_o !== 32'h0 ||
            tx_vld !== 1'b0 || rx_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset: ack=%b dat=%h tx_vld=%b rx_rdy=%b, required 0 00000000 0 1",
                     bus.xwb_ack_o, bus.xwb_dat_o, tx_vld, rx_rdy);
        end
        bus_idle();
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (bus.xwb_ack_o !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL dropped_req_ack: ack seen %0d cycles, required 0", bad);
        end
        bus_req(1'b0, 1'b1, 3'd0, 32'h0, got, w, rd);
        n_cmp++;
        if (!got || rd !== 32'h0) begin
            n_err++;
            $display("FAIL rx_empty_after_reset: got=%b dat=%h, required 1 00000000", got, rd);
        end
    endtask

    initial begin
        bus_idle();
        test_reset();
        test_single_put();
        test_tx_full();
        test_rx_get();
        test_simul_tx();
        test_rx_full_wrap();
        test_addr_decode();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
